seq_pattern_detector: RTL and testbench

Parametrised serial bit-stream detector, successor to the fixed two-bit Moore detector. Matches either a runtime-programmed bit pattern of 1..PAT_W bits or a run of N identical consecutive bits. Supports overlapping and non-overlapping detection, gated by an input-valid qualifier. Sits on the serial input path; its registered `detect` pulse and saturating match counter feed downstream control and status logic.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_det_sat_counter.sv | 34 +++
 rtl/seq_pattern_detector.sv | 148 ++++++++++++++
 tb/tb_seq_pattern_detector.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the serial pattern / equal-run detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } seq_det_state_t;

    localparam logic MODE_PATTERN = 1'b0;
    localparam logic MODE_RUN     = 1'b1;

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating up-counter; a synchronous clear takes priority over an increment.
module seq_det_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-stream detector: programmable pattern of 1..PAT_W bits or a run of
// identical bits, with overlapping / non-overlapping detection and a match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter  int PAT_W = 8,
    parameter  int CNT_W = 16,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_mode,
    input  logic             cfg_overlap,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cnt_clear,
    output logic             detect,
    output logic             armed,
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_count
);

    seq_det_state_t   state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic             ovl_q, ovl_d;
    logic             detect_q, detect_d;
    logic             cfg_err_q, cfg_err_d;
    logic             armed_q;

    logic             len_legal;
    logic [PAT_W-1:0] len_mask;
    logic [PAT_W-1:0] hist_shift;
    logic [PAT_W-1:0] window;
    logic [LEN_W-1:0] fill_inc;
    logic             window_match;
    logic             match;

    assign len_legal  = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
    assign hist_shift = {hist_q[PAT_W-2:0], in_bit};

    // Only the newest len_q bits of the shifted history take part in the compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    assign window   = hist_shift & len_mask;
    assign fill_inc = (fill_q == len_q) ? fill_q : fill_q + 1'b1;

    always_comb begin
        if (mode_q == MODE_RUN) begin
            window_match = (window == '0) || (window == len_mask);
        end else begin
            window_match = (window == (pat_q & len_mask));
        end
    end

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        mode_d    = mode_q;
        ovl_d     = ovl_q;
        detect_d  = 1'b0;
        cfg_err_d = 1'b0;
        match     = 1'b0;

        if (cfg_load) begin
            if (len_legal) begin
                pat_d   = cfg_pattern;
                len_d   = cfg_len;
                mode_d  = cfg_mode;
                ovl_d   = cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                state_d = FILL;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else if (in_valid && (state_q != UNCFG)) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (fill_inc == len_q) begin
                state_d = ARMED;
                if (window_match) begin
                    match    = 1'b1;
                    detect_d = 1'b1;
                    if (!ovl_q) begin
                        fill_d  = '0;
                        state_d = FILL;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= UNCFG;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            mode_q    <= 1'b0;
            ovl_q     <= 1'b0;
            detect_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            ovl_q     <= ovl_d;
            detect_q  <= detect_d;
            cfg_err_q <= cfg_err_d;
            armed_q   <= (state_d == ARMED);
        end
    end

    seq_det_sat_counter #(
        .CNT_W (CNT_W)
    ) u_count (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cnt_clear),
        .inc_i   (match),
        .count_o (match_count)
    );

    assign detect  = detect_q;
    assign armed   = armed_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector with a queue-based reference model.
module tb_seq_pattern_detector;

    localparam int PAT_W = 8;
    localparam int CNT_W = 2;
    localparam int LEN_W = $clog2(PAT_W + 1);
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] cfg_pattern = '0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic             cfg_mode = 1'b0;
    logic             cfg_overlap = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_bit = 1'b0;
    logic             cnt_clear = 1'b0;
    logic             detect;
    logic             armed;
    logic             cfg_err;
    logic [CNT_W-1:0] match_count;

    int n_checks = 0;
    int n_errors = 0;
    int det_seen = 0;

    // reference model state
    bit               m_cfg = 1'b0;
    logic [PAT_W-1:0] m_pat = '0;
    int               m_len = 0;
    bit               m_mode = 1'b0;
    bit               m_ovl = 1'b0;
    bit               m_bits[$];
    int               m_fresh = 0;
    int               m_count = 0;
    bit               exp_detect = 1'b0;
    bit               exp_armed = 1'b0;
    bit               exp_cfg_err = 1'b0;

    seq_pattern_detector #(
        .PAT_W (PAT_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_mode    (cfg_mode),
        .cfg_overlap (cfg_overlap),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .cnt_clear   (cnt_clear),
        .detect      (detect),
        .armed       (armed),
        .cfg_err     (cfg_err),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_cfg = 1'b0;
        m_pat = '0;
        m_len = 0;
        m_bits.delete();
        m_fresh = 0;
        m_count = 0;
        exp_detect = 1'b0;
        exp_armed = 1'b0;
        exp_cfg_err = 1'b0;
    endtask

    // Applies the inputs present at the edge just taken.
    task automatic model_step();
        bit hit;
        bit ok;
        int sz;
        hit = 1'b0;
        exp_detect = 1'b0;
        exp_cfg_err = 1'b0;
        if (cfg_load) begin
            if (int'(cfg_len) >= 1 && int'(cfg_len) <= PAT_W) begin
                m_cfg = 1'b1;
                m_pat = cfg_pattern;
                m_len = int'(cfg_len);
                m_mode = cfg_mode;
                m_ovl = cfg_overlap;
                m_bits.delete();
                m_fresh = 0;
            end else begin
                exp_cfg_err = 1'b1;
            end
        end else if (in_valid && m_cfg) begin
            m_bits.push_back(in_bit);
            if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
            m_fresh++;
            if (m_fresh >= m_len) begin
                sz = m_bits.size();
                ok = 1'b1;
                for (int k = 0; k < m_len; k++) begin
                    if (m_mode) begin
                        if (m_bits[sz-1-k] != m_bits[sz-1]) ok = 1'b0;
                    end else begin
                        if (m_bits[sz-1-k] != m_pat[k]) ok = 1'b0;
                    end
                end
                if (ok) begin
                    hit = 1'b1;
                    exp_detect = 1'b1;
                    if (!m_ovl) m_fresh = 0;
                end
            end
        end
        if (cnt_clear) m_count = 0;
        else if (hit && m_count < CNT_MAX) m_count++;
        exp_armed = m_cfg && (m_fresh >= m_len);
    endtask

    always @(negedge clk) begin
        check("detect", int'(detect), int'(exp_detect));
        check("armed", int'(armed), int'(exp_armed));
        check("cfg_err", int'(cfg_err), int'(exp_cfg_err));
        check("match_count", int'(match_count), m_count);
        if (detect === 1'b1) det_seen++;
    end

    task automatic cycle(input logic ld, input logic v, input logic b, input logic clr);
        cfg_load = ld;
        in_valid = v;
        in_bit = b;
        cnt_clear = clr;
        @(posedge clk);
        #1;
        model_step();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        cnt_clear = 1'b0;
    endtask

    task automatic configure(input logic [PAT_W-1:0] pat, input int len, input logic mode,
                             input logic ovl);
        cfg_pattern = pat;
        cfg_len = LEN_W'(len);
        cfg_mode = mode;
        cfg_overlap = ovl;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Sends seq[n-1] first.
    task automatic send(input logic [31:0] seq, input int n);
        for (int i = n - 1; i >= 0; i--) cycle(1'b0, 1'b1, seq[i], 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_count();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    int d0;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        idle();
        check("reset_count", int'(match_count), 0);
        check("reset_armed", int'(armed), 0);

        // input ignored while unconfigured
        send(32'b111, 3);
        idle();
        check("uncfg_count", int'(match_count), 0);

        // pattern 1011, overlapping
        configure(8'b1011, 4, 1'b0, 1'b1);
        d0 = det_seen;
        send(32'b1011011, 7);
        idle();
        check("ovl_pulses", det_seen - d0, 2);
        check("ovl_count", int'(match_count), 2);

        // same pattern, non-overlapping
        clear_count();
        configure(8'b1011, 4, 1'b0, 1'b0);
        d0 = det_seen;
        send(32'b1011011, 7);
        idle();
        check("novl_pulses", det_seen - d0, 1);
        check("novl_count", int'(match_count), 1);

        // run of three, overlapping
        clear_count();
        configure(8'b0, 3, 1'b1, 1'b1);
        d0 = det_seen;
        send(32'b0000111, 7);
        idle();
        check("run_pulses", det_seen - d0, 3);
        check("run_count", int'(match_count), 3);

        // illegal loads keep the old config and history
        clear_count();
        configure(8'b1011, 4, 1'b0, 1'b1);
        send(32'b101, 3);
        d0 = det_seen;
        configure(8'hFF, 0, 1'b1, 1'b0);
        configure(8'hFF, PAT_W + 1, 1'b1, 1'b0);
        send(32'b1, 1);
        idle();
        check("cfgerr_keep_pulses", det_seen - d0, 1);
        check("cfgerr_keep_count", int'(match_count), 1);

        // saturation with a single-bit pattern
        clear_count();
        configure(8'b1, 1, 1'b0, 1'b1);
        d0 = det_seen;
        send(32'b111111, 6);
        idle();
        check("sat_pulses", det_seen - d0, 6);
        check("sat_count", int'(match_count), CNT_MAX);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        idle();
        check("clear_wins", int'(match_count), 0);

        // gapped input still matches
        configure(8'b1011, 4, 1'b0, 1'b1);
        send(32'b1, 1);
        idle();
        send(32'b0, 1);
        idle();
        idle();
        send(32'b11, 2);
        idle();
        check("gap_count", int'(match_count), 1);

        // asynchronous reset mid-fill
        configure(8'b1011, 4, 1'b0, 1'b1);
        send(32'b10, 2);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check("arst_detect", int'(detect), 0);
        check("arst_count", int'(match_count), 0);
        check("arst_cfg_err", int'(cfg_err), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        send(32'b1011, 4);
        idle();
        check("arst_ignored_count", int'(match_count), 0);
        configure(8'b1011, 4, 1'b0, 1'b0);
        d0 = det_seen;
        send(32'b1, 1);
        idle();
        send(32'b01, 2);
        idle();
        send(32'b1, 1);
        idle();
        check("arst_gap_pulses", det_seen - d0, 1);

        // randomised tail, model-checked on every cycle
        configure(8'b0110, 4, 1'b0, 1'b1);
        for (int i = 0; i < 200; i++) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0));
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
